// File: rtl/pcie_rx.sv
// Receive-side TLP parser: decodes MWr/MRd/CplD from the 64-bit AXI-stream RX port,
// emitting qword write strobes, a held read request and a completion data stream.
module pcie_rx #(
  parameter int ADDR_BITS = 13
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [63:0]          axis_rx_tdata,
  input  logic                 axis_rx_tvalid,
  input  logic                 axis_rx_tlast,
  output logic                 axis_rx_tready,
  output logic                 wr_valid,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [63:0]          wr_data,
  output logic [1:0]           wr_dw_valid,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [23:0]          rd_rid_tag,
  output logic [ADDR_BITS-1:0] rd_addr,
  output logic [9:0]           rd_len_dw,
  output logic                 cpl_valid,
  output logic [7:0]           cpl_tag,
  output logic [63:0]          cpl_data,
  output logic [1:0]           cpl_dw_valid,
  output logic                 cpl_last,
  output logic [15:0]          unsupported_count
);

  typedef enum logic [1:0] {HDR0, HDR1, DATA, DRAIN} state_t;

  localparam logic [6:0] T_MWR32 = 7'b1000000;
  localparam logic [6:0] T_MWR64 = 7'b1100000;
  localparam logic [6:0] T_MRD32 = 7'b0000000;
  localparam logic [6:0] T_MRD64 = 7'b0100000;
  localparam logic [6:0] T_CPLD  = 7'b1001010;

  state_t                 r_state;
  logic [6:0]             r_type;
  logic [9:0]             r_len;
  logic [23:0]            r_rid_tag;
  logic [ADDR_BITS-1:0]   r_addr;
  logic [10:0]            r_rem;
  logic [31:0]            r_pend;
  logic                   r_flush;

  logic                   w_acc;
  logic [31:0]            w_lo;
  logic [31:0]            w_hi;
  logic [6:0]             w_hdr_type;
  logic                   w_hdr_ok;
  logic                   w_is_rd;
  logic                   w_is_cpl;
  logic                   w_4dw;
  logic [10:0]            w_len_full;
  logic [ADDR_BITS-1:0]   w_hdr_addr;
  logic [ADDR_BITS-1:0]   w_emit_addr;
  logic                   w_emit;
  logic                   w_emit_last;
  logic [63:0]            w_emit_q;
  logic [1:0]             w_emit_dwv;

  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  assign axis_rx_tready = ~(rd_valid & ~rd_ready);
  assign w_acc          = axis_rx_tvalid & axis_rx_tready;
  assign w_lo           = axis_rx_tdata[31:0];
  assign w_hi           = axis_rx_tdata[63:32];
  assign w_hdr_type     = axis_rx_tdata[30:24];
  assign w_hdr_ok       = (w_hdr_type == T_MWR32) || (w_hdr_type == T_MWR64) ||
                          (w_hdr_type == T_MRD32) || (w_hdr_type == T_MRD64) ||
                          (w_hdr_type == T_CPLD);
  assign w_is_rd        = (r_type == T_MRD32) || (r_type == T_MRD64);
  assign w_is_cpl       = (r_type == T_CPLD);
  assign w_4dw          = r_type[5];
  assign w_len_full     = (r_len == 10'd0) ? 11'd1024 : {1'b0, r_len};
  assign w_hdr_addr     = w_4dw ? w_hi[ADDR_BITS+2:3] : w_lo[ADDR_BITS+2:3];
  assign w_emit_addr    = (r_state == HDR1) ? w_hdr_addr : r_addr;

  // A 3DW odd-length TLP completes two qwords on its final beat; the lone tail
  // qword is emitted one cycle later from r_pend via r_flush.
  always_comb begin
    w_emit      = 1'b0;
    w_emit_q    = 64'h0;
    w_emit_dwv  = 2'b00;
    w_emit_last = 1'b0;
    if (r_flush) begin
      w_emit      = 1'b1;
      w_emit_q    = {32'h0, bswap(r_pend)};
      w_emit_dwv  = 2'b01;
      w_emit_last = 1'b1;
    end else if (w_acc && (r_state == HDR1) && !w_is_rd && !w_4dw &&
                 ((w_len_full == 11'd1) || axis_rx_tlast)) begin
      w_emit      = 1'b1;
      w_emit_q    = {32'h0, bswap(w_hi)};
      w_emit_dwv  = 2'b01;
      w_emit_last = 1'b1;
    end else if (w_acc && (r_state == DATA)) begin
      if (!w_4dw) begin
        if (r_rem != 11'd0) begin
          w_emit      = 1'b1;
          w_emit_q    = {bswap(w_lo), bswap(r_pend)};
          w_emit_dwv  = 2'b11;
          w_emit_last = (r_rem == 11'd1);
        end
      end else if (r_rem > 11'd1) begin
        w_emit      = 1'b1;
        w_emit_q    = {bswap(w_hi), bswap(w_lo)};
        w_emit_dwv  = 2'b11;
        w_emit_last = (r_rem == 11'd2);
      end else if (r_rem == 11'd1) begin
        w_emit      = 1'b1;
        w_emit_q    = {32'h0, bswap(w_lo)};
        w_emit_dwv  = 2'b01;
        w_emit_last = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state           <= HDR0;
      r_type            <= 7'h0;
      r_len             <= 10'h0;
      r_rid_tag         <= 24'h0;
      r_addr            <= '0;
      r_rem             <= 11'h0;
      r_pend            <= 32'h0;
      r_flush           <= 1'b0;
      wr_valid          <= 1'b0;
      wr_addr           <= '0;
      wr_data           <= 64'h0;
      wr_dw_valid       <= 2'b00;
      rd_valid          <= 1'b0;
      rd_rid_tag        <= 24'h0;
      rd_addr           <= '0;
      rd_len_dw         <= 10'h0;
      cpl_valid         <= 1'b0;
      cpl_tag           <= 8'h0;
      cpl_data          <= 64'h0;
      cpl_dw_valid      <= 2'b00;
      cpl_last          <= 1'b0;
      unsupported_count <= 16'h0;
    end else begin
      wr_valid  <= 1'b0;
      cpl_valid <= 1'b0;
      cpl_last  <= 1'b0;
      r_flush   <= 1'b0;
      if (rd_valid && rd_ready) rd_valid <= 1'b0;

      if (w_acc) begin
        case (r_state)
          HDR0: begin
            r_type    <= w_hdr_type;
            r_len     <= w_lo[9:0];
            r_rid_tag <= w_hi[31:8];
            if (!w_hdr_ok) begin
              if (unsupported_count != 16'hFFFF) unsupported_count <= unsupported_count + 16'd1;
              r_state <= axis_rx_tlast ? HDR0 : DRAIN;
            end else begin
              r_state <= axis_rx_tlast ? HDR0 : HDR1;
            end
          end
          HDR1: begin
            r_addr <= w_hdr_addr;
            r_pend <= w_hi;
            r_rem  <= w_4dw ? w_len_full : w_len_full - 11'd1;
            if (w_is_rd) begin
              rd_valid   <= 1'b1;
              rd_rid_tag <= r_rid_tag;
              rd_addr    <= w_hdr_addr;
              rd_len_dw  <= r_len;
              r_state    <= axis_rx_tlast ? HDR0 : DRAIN;
            end else begin
              if (w_is_cpl) cpl_tag <= w_lo[15:8];
              if (axis_rx_tlast)                            r_state <= HDR0;
              else if (!w_4dw && (w_len_full == 11'd1))     r_state <= DRAIN;
              else                                          r_state <= DATA;
            end
          end
          DATA: begin
            if (!w_4dw) begin
              if (r_rem > 11'd1) begin
                r_pend <= w_hi;
                r_rem  <= r_rem - 11'd2;
                if ((r_rem == 11'd2) || axis_rx_tlast) r_flush <= 1'b1;
              end else begin
                r_rem <= 11'd0;
              end
            end else begin
              r_rem <= (r_rem > 11'd1) ? r_rem - 11'd2 : 11'd0;
            end
            if (axis_rx_tlast)         r_state <= HDR0;
            else if (r_rem <= 11'd2)   r_state <= DRAIN;
          end
          DRAIN: begin
            if (axis_rx_tlast) r_state <= HDR0;
          end
          default: r_state <= HDR0;
        endcase
      end

      if (w_emit) begin
        if (w_is_cpl) begin
          cpl_valid    <= 1'b1;
          cpl_data     <= w_emit_q;
          cpl_dw_valid <= w_emit_dwv;
          cpl_last     <= w_emit_last;
        end else begin
          wr_valid    <= 1'b1;
          wr_addr     <= w_emit_addr;
          wr_data     <= w_emit_q;
          wr_dw_valid <= w_emit_dwv;
        end
        r_addr <= w_emit_addr + 1'b1;
      end
    end
  end

endmodule
